job_seq_ctrl: RTL and testbench
===============================

// Module: job_seq_ctrl
// PURPOSE
//  Sequencer in front of the A/B instruction datapath and its third-largest tracker.
//  Accepts a job (start + count) and up to count valid operand beats with gaps.
//  Issues each beat to the ALU as a registered op, counts returned results, clears/enables the tracker.
//  Emits a single-cycle finish pulse once all count results have retired.
// PARAMETERS
//  DW          8   operand width (data_A/data_B/op_a/op_b)
//  IW          4   instruction/opcode width
//  CW          8   job count width
//  TIMEOUT_CYC 32  idle cycles (no valid, no res_valid) in RUN/DRAIN before abort
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  start        in   1   job start strobe, sampled only in IDLE
//  count        in   CW  number of beats in job, sampled with start
//  valid        in   1   operand beat present this cycle
//  instruction  in   IW  opcode of current beat
//  data_A       in   DW  operand A
//  data_B       in   DW  operand B
//  op_valid     out  1   registered issue strobe to ALU
//  op_code      out  IW  registered opcode
//  op_a         out  DW  registered operand A
//  op_b         out  DW  registered operand B
//  res_valid    in   1   ALU result strobe (any latency >= 1)
//  trk_clr      out  1   one-cycle tracker clear at job accept
//  trk_en       out  1   tracker update enable
//  busy         out  1   high in RUN, DRAIN and DONE
//  finish       out  1   one-cycle job-complete pulse, registered
//  err          out  1   sticky until next accepted start: timeout abort or spurious res_valid
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; op_code/op_a/op_b=0; issued=retired=0; watchdog=0.
//  rst in any state, including mid-job, returns to the reset state next edge.
//  There is no partial finish on reset.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 latches count into job_cnt, clears issued/retired/err and pulses trk_clr for 1 cycle.
//   -> RUN when count!=0; -> DONE when count==0.
//  RUN: valid=1 && issued<job_cnt -> next cycle op_valid=1 with captured instruction/A/B; issued++.
//   Issue latency is exactly 1 cycle. valid=0 issues nothing (op_valid=0, op fields hold).
//   When issued reaches job_cnt -> DRAIN.
//   valid beats beyond job_cnt are dropped.
//  RUN/DRAIN: trk_en = res_valid (combinational pass-through); each res_valid increments retired.
//  DRAIN: retired==job_cnt -> DONE.
//   An issue and a retire in the same cycle both take effect.
//   The last retire may coincide with the last issue only at ALU latency 0, which is unsupported.
//  DONE: finish=1 for exactly one cycle, asserted from the posedge entering DONE; -> IDLE.
//  start outside IDLE: ignored and does not queue.
//  start in the same cycle finish is high: ignored; the next job needs start in IDLE.
//  res_valid in IDLE/DONE, or with retired==job_cnt: ignored for counting, sets err, trk_en=0.
//  Watchdog: in RUN/DRAIN it counts cycles with valid=0 && res_valid=0, and resets to 0 on either.
//   At TIMEOUT_CYC -> DONE with err=1; finish still pulses once.
//  Widths: issued/retired/job_cnt are CW bits; max job 2^CW-1, no wrap.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/DRAIN/DONE), DW/IW/CW defaults, TIMEOUT_CYC default.
//  Sub-module job_watchdog: saturating idle counter with clr/inc, asserting expire at TIMEOUT_CYC.
//  Everything else is flat: FSM, two counters, op register bank.
// TESTING
//  count=3, valid back-to-back (A,B)=(5,9),(1,2),(7,7), ALU lat 1 -> op_valid 3 consecutive cycles, trk_clr at accept, finish 1 cycle after 3rd res_valid.
//  count=4, valid 1-on/1-off, ALU lat 3 -> 4 issues each 1 cycle after its beat, finish single cycle at posedge, busy low after.
//  count=0 -> trk_clr=1 and finish=1 on consecutive cycles, op_valid never 1, err=0.
//  count=2 with 5 valid beats; start pulsed again mid-RUN -> only 2 issues, second start ignored, one finish.
//  count=2, one res_valid then silence 32 cycles -> finish pulse, err=1; next start clears err.
//  rst asserted in DRAIN with 1 result outstanding -> all outputs 0 next edge, no finish; fresh job count=1 completes normally.

Source files
------------

// File: rtl/job_seq_ctrl_pkg.sv
// job_seq_ctrl_pkg: shared defaults and FSM state encoding for the job sequencer
package job_seq_ctrl_pkg;
    localparam int DW_DEF      = 8;
    localparam int IW_DEF      = 4;
    localparam int CW_DEF      = 8;
    localparam int TIMEOUT_DEF = 32;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/job_seq_ctrl_watchdog.sv
// job_watchdog: saturating idle-cycle counter, expire fires on the LIMIT-th consecutive idle cycle
module job_watchdog
    import job_seq_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int WW = $clog2(LIMIT + 1);
    logic [WW-1:0] cnt_q;
    assign expire = inc && (cnt_q == WW'(LIMIT - 1));
    // count consecutive idle cycles, cleared by any activity, held at LIMIT
    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else if (inc && cnt_q != WW'(LIMIT)) cnt_q <= cnt_q + WW'(1);
    end
endmodule

// File: rtl/job_seq_ctrl.sv
// job_seq_ctrl: accepts a job, issues operand beats to the ALU, retires results, pulses finish
module job_seq_ctrl
    import job_seq_ctrl_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int IW          = IW_DEF,
    parameter int CW          = CW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic          valid,
    input  logic [IW-1:0] instruction,
    input  logic [DW-1:0] data_A,
    input  logic [DW-1:0] data_B,
    output logic          op_valid,
    output logic [IW-1:0] op_code,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    input  logic          res_valid,
    output logic          trk_clr,
    output logic          trk_en,
    output logic          busy,
    output logic          finish,
    output logic          err
);
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] job_q, issued_q, issued_d, retired_q, retired_d;
    logic          err_q, op_valid_q;
    logic [IW-1:0] op_code_q;
    logic [DW-1:0] op_a_q, op_b_q;
    logic          active, accept, issue, can_ret, retire, expire;

    assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign accept    = (state_q == S_IDLE) && start;
    assign issue     = (state_q == S_RUN) && valid && (issued_q < job_q);
    assign can_ret   = active && (retired_q != job_q);
    assign retire    = res_valid && can_ret;
    assign issued_d  = accept ? '0 : issued_q + CW'(issue);
    assign retired_d = accept ? '0 : retired_q + CW'(retire);

    assign op_valid = op_valid_q;
    assign op_code  = op_code_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign trk_clr  = accept;
    assign trk_en   = retire;
    assign busy     = state_q != S_IDLE;
    assign finish   = state_q == S_DONE;
    assign err      = err_q;

    job_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!active || valid || res_valid),
        .inc    (active && !valid && !res_valid),
        .expire (expire)
    );

    // job FSM: abort on watchdog, otherwise advance on issue/retire completion
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) state_d = !start ? S_IDLE : (count != '0 ? S_RUN : S_DONE);
        else if (state_q == S_DONE) state_d = S_IDLE;
        else if (expire) state_d = S_DONE;
        else if (state_q == S_DRAIN) state_d = (retired_d == job_q) ? S_DONE : S_DRAIN;
        else state_d = (issued_d == job_q) ? S_DRAIN : S_RUN;
    end

    // state, counters, sticky error and the registered op bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            job_q      <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_code_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            retired_q  <= retired_d;
            err_q      <= (accept ? 1'b0 : err_q) | (res_valid && !can_ret) | expire;
            op_valid_q <= issue;
            if (accept) job_q <= count;
            if (issue) begin
                op_code_q <= instruction;
                op_a_q    <= data_A;
                op_b_q    <= data_B;
            end
        end
    end
endmodule

// File: tb/tb_job_seq_ctrl.sv
// tb_job_seq_ctrl: randomized scoreboard bench for job_seq_ctrl
module tb_job_seq_ctrl;
    import job_seq_ctrl_pkg::*;
    localparam int DW = DW_DEF;
    localparam int IW = IW_DEF;
    localparam int CW = CW_DEF;

    typedef struct {int c; logic [IW-1:0] i; logic [DW-1:0] a; logic [DW-1:0] b;} op_t;
    typedef struct {int c; logic e;} fin_t;

    logic clk = 1'b0, rst, start, valid, res_valid;
    logic [CW-1:0] count;
    logic [IW-1:0] instruction, op_code;
    logic [DW-1:0] data_A, data_B, op_a, op_b;
    logic op_valid, trk_clr, trk_en, busy, finish, err;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    op_t op_q[$];
    fin_t fin_q[$];
    int clr_q[$];
    op_t oe;
    fin_t fe;
    int ce;
    logic [IW-1:0] fi[8];
    logic [DW-1:0] fa[8], fb[8];

    job_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .valid(valid),
        .instruction(instruction), .data_A(data_A), .data_B(data_B),
        .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .trk_clr(trk_clr), .trk_en(trk_en),
        .busy(busy), .finish(finish), .err(err)
    );

    always #5 clk = ~clk;

    // cycle stamp shared by driver and monitor
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: cyc=%0d got=%0h exp=%0h", n, cyc, got, exp);
        end
    endtask

    // monitor: pops expected events whenever the DUT presents one
    always @(negedge clk) begin
        if (mon_en) begin
            if (op_valid) begin
                total++;
                if (op_q.size() == 0) begin
                    bad++;
                    $display("FAIL op_unexpected: cyc=%0d ins=%0h a=%0h b=%0h", cyc, op_code, op_a, op_b);
                end else begin
                    oe = op_q.pop_front();
                    if (oe.c != cyc || oe.i !== op_code || oe.a !== op_a || oe.b !== op_b) begin
                        bad++;
                        $display("FAIL op: got cyc=%0d ins=%0h a=%0h b=%0h exp cyc=%0d ins=%0h a=%0h b=%0h",
                                 cyc, op_code, op_a, op_b, oe.c, oe.i, oe.a, oe.b);
                    end
                end
            end
            if (finish) begin
                total++;
                if (fin_q.size() == 0) begin
                    bad++;
                    $display("FAIL finish_unexpected: cyc=%0d", cyc);
                end else begin
                    fe = fin_q.pop_front();
                    if (fe.c != cyc || fe.e !== err) begin
                        bad++;
                        $display("FAIL finish: got cyc=%0d err=%b exp cyc=%0d err=%b", cyc, err, fe.c, fe.e);
                    end
                end
            end
            if (trk_clr) begin
                total++;
                if (clr_q.size() == 0) begin
                    bad++;
                    $display("FAIL trk_clr_unexpected: cyc=%0d", cyc);
                end else begin
                    ce = clr_q.pop_front();
                    if (ce != cyc) begin
                        bad++;
                        $display("FAIL trk_clr: got cyc=%0d exp cyc=%0d", cyc, ce);
                    end
                end
            end
            if (res_valid || trk_en) begin
                total++;
                if (trk_en !== res_valid) begin
                    bad++;
                    $display("FAIL trk_en: cyc=%0d got=%b exp=%b", cyc, trk_en, res_valid);
                end
            end
        end
    end

    // plan one job from the rules, push expectations, then drive it cycle by cycle
    task automatic run_job(input int n, input int nb, input int gmin, input int gmax, input int lat,
                           input int nres, input int mid, input int rst_at, input bit fixed);
        logic vld[128];
        logic rs[128];
        logic [IW-1:0] ins[128];
        logic [DW-1:0] da[128], db[128];
        int bc[$];
        int t, fin, streak, nis, last, base, stop, msc;
        bit ferr, done;
        for (int i = 0; i < 128; i++) begin
            vld[i] = 0; rs[i] = 0;
            ins[i] = IW'($urandom); da[i] = DW'($urandom); db[i] = DW'($urandom);
        end
        t = 0;
        for (int k = 0; k < nb; k++) begin
            t += 1 + int'($urandom_range(gmax, gmin));
            vld[t] = 1;
            if (fixed) begin ins[t] = fi[k]; da[t] = fa[k]; db[t] = fb[k]; end
            bc.push_back(t);
        end
        nis = nb < n ? nb : n;
        last = 0;
        for (int k = 0; k < nis; k++)
            if (k < nres) begin
                rs[bc[k] + 1 + lat] = 1;
                last = bc[k] + 1 + lat;
            end
        if (rst_at >= 0)
            for (int i = rst_at; i < 128; i++) begin vld[i] = 0; rs[i] = 0; end
        fin = -1;
        ferr = 0;
        done = (nb >= n) && (nres >= n);
        if (rst_at < 0) begin
            if (n == 0) fin = 1;
            else begin
                streak = 0;
                for (int c = 1; c < 127 && fin < 0; c++) begin
                    if (done && c == last + 1) fin = c;
                    else begin
                        streak = (vld[c] || rs[c]) ? 0 : streak + 1;
                        if (streak == TIMEOUT_DEF) begin fin = c + 1; ferr = 1; end
                    end
                end
            end
        end
        msc = (mid == -2) ? fin : mid;
        base = cyc;
        clr_q.push_back(base);
        for (int k = 0; k < nis; k++)
            if (rst_at < 0 || bc[k] < rst_at)
                op_q.push_back('{base + bc[k] + 1, ins[bc[k]], da[bc[k]], db[bc[k]]});
        if (fin >= 0) fin_q.push_back('{base + fin, ferr});
        stop = fin >= 0 ? fin + 2 : rst_at + 2;
        for (int c = 0; c <= stop; c++) begin
            start = (c == 0) || (c == msc);
            count = CW'(n);
            valid = vld[c];
            instruction = ins[c];
            data_A = da[c];
            data_B = db[c];
            res_valid = rs[c];
            rst = (c == rst_at);
            if (c == 1 || (fin >= 0 && (c == fin || c == fin + 1)) || (rst_at >= 0 && c == rst_at + 1)) begin
                @(negedge clk);
                if (c == 1 && rst_at != 1) begin
                    chk("accept_err_clear", err, 0);
                    chk("accept_busy", busy, 1);
                end
                if (fin >= 0 && c == fin) chk("busy_at_finish", busy, 1);
                if (fin >= 0 && c == fin + 1) chk("busy_after_finish", busy, 0);
                if (rst_at >= 0 && c == rst_at + 1)
                    chk("rst_midjob_zero", {op_valid, op_code, op_a, op_b, trk_clr, trk_en, busy, finish, err}, 0);
            end
            @(posedge clk);
            #1;
        end
        start = 0; valid = 0; res_valid = 0; rst = 0;
        chk("ops_drained", op_q.size(), 0);
        chk("finish_drained", fin_q.size(), 0);
        chk("clr_drained", clr_q.size(), 0);
    endtask

    initial begin
        int m, n;
        rst = 1; start = 0; count = '0; valid = 0; res_valid = 0;
        instruction = '0; data_A = '0; data_B = '0;
        fa[0] = 5; fb[0] = 9; fi[0] = 4'h3;
        fa[1] = 1; fb[1] = 2; fi[1] = 4'hA;
        fa[2] = 7; fb[2] = 7; fi[2] = 4'h6;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_state", {op_valid, op_code, op_a, op_b, trk_clr, trk_en, busy, finish, err}, 0);
        mon_en = 1;
        @(posedge clk);
        #1;
        run_job(3, 3, 0, 0, 1, 99, -1, -1, 1);
        run_job(4, 4, 1, 1, 3, 99, -1, -1, 0);
        run_job(0, 0, 0, 0, 1, 99, -1, -1, 0);
        run_job(2, 5, 0, 1, 2, 99, 3, -1, 0);
        run_job(2, 2, 0, 0, 1, 1, -1, -1, 0);
        run_job(1, 1, 0, 2, 2, 99, -1, -1, 0);
        run_job(2, 2, 0, 0, 1, 1, -1, 6, 0);
        run_job(1, 1, 0, 1, 1, 99, -1, -1, 0);
        for (int j = 0; j < 12; j++) begin
            n = 1 + int'($urandom_range(5, 0));
            m = int'($urandom_range(2, 0));
            run_job(n, n + int'($urandom_range(2, 0)), 0, 3, 1 + int'($urandom_range(3, 0)), 99,
                    m == 0 ? -1 : (m == 1 ? 2 : -2), -1, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
